// File: rtl/lut_neuron_pkg.sv
// -----------------------------------------------------------------------------
// lut_neuron_pkg
// Shared definitions for the runtime-loadable LUT neuron: loader state
// encoding, default table geometry and the helpers that derive the number of
// entries carried per load beat and the number of beats per table.
// -----------------------------------------------------------------------------
package lut_neuron_pkg;

  localparam int IN_BITS_DEF  = 8;
  localparam int OUT_BITS_DEF = 2;
  localparam int DATA_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DONE  = 3'd2,
    ERR   = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // Table entries packed into one load beat.
  function automatic int calc_epb(input int data_w, input int out_bits);
    return data_w / out_bits;
  endfunction

  // Beats needed to fill a table of 2**in_bits entries.
  function automatic int calc_nbeats(input int in_bits, input int epb);
    return (2 ** in_bits) / epb;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// -----------------------------------------------------------------------------
// lut_neuron_ram
// Distributed RAM holding one neuron truth table. One write port stores a
// whole load beat (EPB adjacent entries) per cycle; one registered read port
// serves lookups. Contents are not reset; only the read register is.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (read register only)
//   we_i       write a beat of EPB entries
//   wbeat_i    beat index; entry j lands at {wbeat_i, j}
//   wdata_i    EPB packed entries, entry j at [OUT_BITS*j +: OUT_BITS]
//   rd_en_i    read enable; when low the read register loads zero
//   raddr_i    lookup address
//   rdata_o    registered lookup data
// -----------------------------------------------------------------------------
module lut_neuron_ram #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int EPB      = 4,
  localparam int EPB_W   = $clog2(EPB),
  localparam int BEAT_W  = IN_BITS - EPB_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [BEAT_W-1:0]       wbeat_i,
  input  logic [EPB*OUT_BITS-1:0] wdata_i,
  input  logic                    rd_en_i,
  input  logic [IN_BITS-1:0]      raddr_i,
  output logic [OUT_BITS-1:0]     rdata_o
);

  localparam int DEPTH = 2 ** IN_BITS;

  (* ram_style = "distributed" *)
  logic [OUT_BITS-1:0] mem_q [DEPTH];
  logic [OUT_BITS-1:0] rdata_q;

  // Beat-wide write: all EPB entries of one beat in the same cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int j = 0; j < EPB; j++) begin
        mem_q[{wbeat_i, EPB_W'(j)}] <= wdata_i[j*OUT_BITS +: OUT_BITS];
      end
    end
  end

  // Registered read; forced to zero while the table is not usable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= {OUT_BITS{1'b0}};
    end else if (rd_en_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= {OUT_BITS{1'b0}};
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_neuron_loader.sv
// -----------------------------------------------------------------------------
// lut_neuron_loader
// Runtime-writable LUT neuron. A truth table arrives over a valid/ready byte
// stream after a cfg_start pulse and is written into distributed RAM; once a
// correctly framed table has landed, registered lookups (latency 1) return
// the stored activation for a packed fan-in code.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cfg_start      one-cycle pulse starting a table load
//   s_valid/ready  load beat handshake
//   s_data         EPB packed entries per beat
//   s_last         final beat marker
//   busy           high in LOAD or DRAIN
//   done           one-cycle pulse after a good load
//   err            sticky framing error, cleared by the next accepted cfg_start
//   table_valid    table contents usable
//   lk_valid       lookup request
//   lk_addr        packed fan-in code
//   lk_out_valid   lookup result valid (one cycle after request)
//   lk_out         activation
// -----------------------------------------------------------------------------
module lut_neuron_loader
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_last,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                table_valid,
  input  logic                lk_valid,
  input  logic [IN_BITS-1:0]  lk_addr,
  output logic                lk_out_valid,
  output logic [OUT_BITS-1:0] lk_out
);

  localparam int EPB    = calc_epb(DATA_W, OUT_BITS);
  localparam int NBEATS = calc_nbeats(IN_BITS, EPB);
  localparam int CNT_W  = $clog2(NBEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBEATS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tv_q, tv_d;
  logic             lkv_q;
  logic             we_s;
  logic             beat_acc_s;

  assign s_ready    = (state_q == LOAD) || (state_q == DRAIN);
  assign beat_acc_s = s_valid && s_ready;

  // Next-state logic: framing checks, beat counting and flag updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tv_d    = tv_q;
    we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = {CNT_W{1'b0}};
          err_d   = 1'b0;
          tv_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (beat_acc_s) begin
          we_s = 1'b1;
          // Terminal compare happens before the increment, so the counter
          // never wraps past the last beat.
          if (cnt_q == CNT_LAST) begin
            if (s_last) begin
              state_d = DONE;
              tv_d    = 1'b1;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (s_last) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = {CNT_W{1'b0}};
          err_d   = 1'b0;
          tv_d    = 1'b0;
        end else if (beat_acc_s && s_last) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and status flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
      tv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tv_q    <= tv_d;
    end
  end

  // Lookup result valid follows the request by one cycle, gated by the
  // table state seen in the request cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lkv_q <= 1'b0;
    end else begin
      lkv_q <= lk_valid && tv_q;
    end
  end

  lut_neuron_ram #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .EPB      (EPB)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_s),
    .wbeat_i (cnt_q),
    .wdata_i (s_data),
    .rd_en_i (tv_q),
    .raddr_i (lk_addr),
    .rdata_o (lk_out)
  );

  assign busy         = (state_q == LOAD) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign err          = err_q;
  assign table_valid  = tv_q;
  assign lk_out_valid = lkv_q;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// -----------------------------------------------------------------------------
// tb_lut_neuron_loader
// Self-checking bench for lut_neuron_loader. Lookup expectations are pushed
// into a scoreboard queue when a request is driven and popped when the
// result is due one cycle later.
// -----------------------------------------------------------------------------
module tb_lut_neuron_loader;

  logic       clk;
  logic       rst;
  logic       cfg_start;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       busy;
  logic       done;
  logic       err;
  logic       table_valid;
  logic       lk_valid;
  logic [7:0] lk_addr;
  logic       lk_out_valid;
  logic [1:0] lk_out;

  lut_neuron_loader dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .table_valid  (table_valid),
    .lk_valid     (lk_valid),
    .lk_addr      (lk_addr),
    .lk_out_valid (lk_out_valid),
    .lk_out       (lk_out)
  );

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] model_mem [256];
  logic       model_tv;
  int         cyc;
  int         n_chk;
  int         n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [1:0] pat_val(input int pat, input logic [7:0] a);
    case (pat)
      0:       return a[1:0] ^ a[7:6];
      1:       return a[3:2] ^ a[5:4] ^ 2'b01;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Result monitor: pops the expectation due this cycle, flags stray results.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc - 1) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("lk_out_valid", {31'd0, lk_out_valid}, 32'd1);
        check_eq("lk_out", {30'd0, lk_out}, {30'd0, e.val});
      end else if (lk_out_valid) begin
        check_eq("lk_spurious", {31'd0, lk_out_valid}, 32'd0);
      end
    end
  end

  // Drive one cycle of inputs, record any expected lookup, advance a clock.
  task automatic step(input logic cfg, input logic sv, input logic [7:0] sd,
                      input logic sl, input logic lv, input logic [7:0] la);
    exp_t e;
    cfg_start = cfg;
    s_valid   = sv;
    s_data    = sd;
    s_last    = sl;
    lk_valid  = lv;
    lk_addr   = la;
    if (lv && model_tv) begin
      e.cyc = cyc;
      e.val = model_mem[la];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // Send nbeats beats of pattern pat while in LOAD; s_last on beat last_at.
  task automatic load_table(input int pat, input int nbeats, input int last_at,
                            input bit rnd, input bit lk_hold);
    logic [7:0] d;
    logic [7:0] a;
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < 20; g++) begin
        if (!rnd || $urandom_range(0, 1) == 1) break;
        check_eq("s_ready_gap", {31'd0, s_ready}, 32'd1);
        step(1'b0, 1'b0, 8'($urandom), 1'b0, lk_hold, 8'($urandom));
      end
      for (int j = 0; j < 4; j++) begin
        a = 8'(b * 4 + j);
        d[2*j +: 2] = pat_val(pat, a);
        model_mem[a] = pat_val(pat, a);
      end
      check_eq("s_ready_load", {31'd0, s_ready}, 32'd1);
      check_eq("busy_load", {31'd0, busy}, 32'd1);
      step(1'b0, 1'b1, d, (b == last_at), lk_hold, 8'($urandom));
    end
  endtask

  task automatic expect_done();
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("table_valid_done", {31'd0, table_valid}, 32'd1);
    check_eq("err_done", {31'd0, err}, 32'd0);
    model_tv = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; model_tv = 1'b0;
    rst = 1'b1; cfg_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    s_last = 1'b0; lk_valid = 1'b0; lk_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_table_valid", {31'd0, table_valid}, 32'd0);
    check_eq("rst_lk_out_valid", {31'd0, lk_out_valid}, 32'd0);
    check_eq("rst_lk_out", {30'd0, lk_out}, 32'd0);
    rst = 1'b0;

    // Clean load, then sweep every address back to back.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    load_table(0, 64, 63, 1'b0, 1'b0);
    expect_done();
    for (int a = 0; a < 256; a++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(a));
      if (a == 0) check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    end
    idle();

    // Early s_last on beat 10, then drain five beats.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    model_tv = 1'b0;
    load_table(0, 11, 10, 1'b0, 1'b0);
    check_eq("early_err", {31'd0, err}, 32'd1);
    check_eq("early_tv", {31'd0, table_valid}, 32'd0);
    check_eq("early_no_done", {31'd0, done}, 32'd0);
    idle();
    for (int b = 0; b < 5; b++) begin
      check_eq("drain_ready", {31'd0, s_ready}, 32'd1);
      step(1'b0, 1'b1, 8'($urandom), (b == 4), 1'b0, 8'h00);
    end
    check_eq("drain_idle_ready", {31'd0, s_ready}, 32'd0);
    check_eq("drain_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("err_sticky", {31'd0, err}, 32'd1);

    // Missing s_last on beat 63, then abort drain with cfg_start.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check_eq("err_cleared", {31'd0, err}, 32'd0);
    load_table(1, 64, -1, 1'b0, 1'b0);
    check_eq("late_err", {31'd0, err}, 32'd1);
    check_eq("late_tv", {31'd0, table_valid}, 32'd0);
    idle();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check_eq("abort_err_clear", {31'd0, err}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd1);

    // Reload with s_valid toggling randomly.
    load_table(1, 64, 63, 1'b1, 1'b0);
    expect_done();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hff);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom));
    idle();

    // Asynchronous reset in the middle of beat 30.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    model_tv = 1'b0;
    load_table(0, 30, -1, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h5a;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_s_ready", {31'd0, s_ready}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_err", {31'd0, err}, 32'd0);
    check_eq("arst_tv", {31'd0, table_valid}, 32'd0);
    check_eq("arst_lkv", {31'd0, lk_out_valid}, 32'd0);
    check_eq("arst_lk_out", {30'd0, lk_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05);
    check_eq("post_rst_lkv", {31'd0, lk_out_valid}, 32'd0);
    check_eq("post_rst_lk_out", {30'd0, lk_out}, 32'd0);
    check_eq("post_rst_tv", {31'd0, table_valid}, 32'd0);

    // Live table rewrite while lookups stay asserted.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    load_table(0, 64, 63, 1'b0, 1'b0);
    expect_done();
    idle();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h81);
    model_tv = 1'b0;
    check_eq("rewrite_lkv_still", {31'd0, lk_out_valid}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42);
    check_eq("rewrite_lkv_drop", {31'd0, lk_out_valid}, 32'd0);
    check_eq("rewrite_lk_out_zero", {30'd0, lk_out}, 32'd0);
    load_table(2, 64, 63, 1'b0, 1'b1);
    expect_done();
    for (int a = 0; a < 256; a++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(a));
    idle();
    idle();

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
